// File: rtl/pbs_battle_datapath_pkg.sv
// -----------------------------------------------------------------------------
// pbs_pkg
// Shared definitions for the PBS battle datapath:
//   - step command one-hot encoding and its priority resolver
//   - internal step FSM state encoding
//   - 16-bit Fibonacci LFSR tap mask (taps 16,14,13,11)
//   - move power / accuracy tables and the hit-roll helper
// No ports; imported by the interface, the LFSR and the datapath top.
// -----------------------------------------------------------------------------
package pbs_pkg;

    // One-hot step commands. Bit 0 has the highest priority, bit 5 the lowest.
    typedef logic [5:0] cmd_t;

    localparam cmd_t CMD_NONE     = 6'b000000;
    localparam cmd_t CMD_LD_PM    = 6'b000001;
    localparam cmd_t CMD_CALC_PH  = 6'b000010;
    localparam cmd_t CMD_APPLY_AD = 6'b000100;
    localparam cmd_t CMD_LD_AM    = 6'b001000;
    localparam cmd_t CMD_CALC_AH  = 6'b010000;
    localparam cmd_t CMD_APPLY_PD = 6'b100000;

    // Step FSM. Non-apply steps: IDLE -> EXEC -> DONE -> IDLE.
    // Apply steps:              IDLE -> DRAIN (n cycles) -> DONE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Keep only the highest-priority (lowest index) asserted command.
    function automatic cmd_t cmd_priority(input cmd_t raw);
        return raw & (~raw + 6'd1);
    endfunction

    function automatic logic [7:0] move_power(input logic [1:0] mv);
        logic [7:0] p;
        p = 8'd10;
        case (mv)
            2'd0: p = 8'd10;
            2'd1: p = 8'd20;
            2'd2: p = 8'd35;
            2'd3: p = 8'd50;
            default: p = 8'd10;
        endcase
        return p;
    endfunction

    // Accuracy out of 256; move 0 (acc 256) can never miss.
    function automatic logic [8:0] move_acc(input logic [1:0] mv);
        logic [8:0] a;
        a = 9'd256;
        case (mv)
            2'd0: a = 9'd256;
            2'd1: a = 9'd192;
            2'd2: a = 9'd128;
            2'd3: a = 9'd64;
            default: a = 9'd256;
        endcase
        return a;
    endfunction

    function automatic logic roll_hit(input logic [7:0] rnd, input logic [1:0] mv);
        return ({1'b0, rnd} < move_acc(mv));
    endfunction

endpackage

// File: rtl/pbs_battle_datapath_if.sv
// -----------------------------------------------------------------------------
// pbs_battle_datapath_if
// Command/status bundle between the PBS battle control FSM (master) and the
// battle datapath (slave).
//   master -> slave : start_battle, move_in[1:0], ld_pm, calc_ph, apply_ad,
//                     ld_am, calc_ah, apply_pd
//   slave -> master : step_done, player_hit, ai_hit, crit, player_hp[7:0],
//                     ai_hp[7:0], player_fainted, ai_fainted,
//                     dbg_state (step FSM), dbg_lfsr[15:0] (random source)
//
// Handshake: a command is a level held by the master for as long as it sits in
// the corresponding control state. The slave starts a step when the
// prioritised command is nonzero and differs from the one it last accepted,
// and answers with a one-cycle step_done pulse when the step completes. A
// command held past step_done is not re-executed; it must drop to zero (or
// change to another command) before the same step can run again.
// -----------------------------------------------------------------------------
interface pbs_battle_datapath_if;
    import pbs_pkg::*;

    logic        start_battle;
    logic [1:0]  move_in;
    logic        ld_pm;
    logic        calc_ph;
    logic        apply_ad;
    logic        ld_am;
    logic        calc_ah;
    logic        apply_pd;

    logic        step_done;
    logic        player_hit;
    logic        ai_hit;
    logic        crit;
    logic [7:0]  player_hp;
    logic [7:0]  ai_hp;
    logic        player_fainted;
    logic        ai_fainted;
    state_t      dbg_state;
    logic [15:0] dbg_lfsr;

    modport master (
        output start_battle, move_in, ld_pm, calc_ph, apply_ad,
               ld_am, calc_ah, apply_pd,
        input  step_done, player_hit, ai_hit, crit, player_hp, ai_hp,
               player_fainted, ai_fainted, dbg_state, dbg_lfsr
    );

    modport slave (
        input  start_battle, move_in, ld_pm, calc_ph, apply_ad,
               ld_am, calc_ah, apply_pd,
        output step_done, player_hit, ai_hit, crit, player_hp, ai_hp,
               player_fainted, ai_fainted, dbg_state, dbg_lfsr
    );

endinterface

// File: rtl/pbs_battle_datapath_lfsr.sv
// -----------------------------------------------------------------------------
// pbs_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clock.
//   clk    : clock
//   resetn : synchronous active-low reset, loads SEED
//   out    : current LFSR state
// SEED must be nonzero or the register locks up at zero.
// -----------------------------------------------------------------------------
module pbs_lfsr16
    import pbs_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out <= SEED;
        end else begin
            out <= {out[14:0], ^(out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pbs_battle_datapath.sv
// -----------------------------------------------------------------------------
// pbs_battle_datapath
// Executes the step commands of the PBS battle control FSM: move latch, hit
// roll and HP damage. Damage drains HP one point per clock so health bars
// animate.
//
// Ports:
//   clk    : clock, all state changes on posedge
//   resetn : synchronous active-low reset
//   bus    : pbs_battle_datapath_if.slave (commands in, status out)
//
// Parameters:
//   MAX_HP    : starting / restored HP of both fighters (1..255)
//   LFSR_SEED : LFSR reset value, nonzero
//
// Build option:
//   PBS_CRIT_HIT_EN : when defined, a hit with rnd[7:5]==0 deals double power
//                     and raises crit. Undefined: crit tied 0.
// -----------------------------------------------------------------------------
module pbs_battle_datapath
    import pbs_pkg::*;
#(
    parameter int          MAX_HP    = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  resetn,
    pbs_battle_datapath_if.slave  bus
);

    localparam logic [7:0] HP_INIT = 8'(MAX_HP);

    // -------------------------------------------------------------------------
    // Random source
    // -------------------------------------------------------------------------
    logic [15:0] lfsr;
    logic [7:0]  rnd;

    pbs_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .out    (lfsr)
    );

    assign rnd = lfsr[7:0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    cmd_t        raw_cmd;
    cmd_t        cmd;
    cmd_t        last_cmd;
    logic [1:0]  pmove;
    logic [1:0]  amove;
    logic [7:0]  dmg;
    logic [7:0]  dcnt;
    logic        drain_ai;      // 1: current drain targets the AI, 0: the player
    logic [7:0]  player_hp;
    logic [7:0]  ai_hp;
    logic        player_hit;
    logic        ai_hit;

    logic        step_start;
    logic        cmd_is_apply;
    logic [7:0]  tgt_hp;
    logic        drain_dec;

    logic [1:0]  roll_move;
    logic [7:0]  roll_power;
    logic        roll_hit_w;
    logic        roll_crit;
    logic [7:0]  roll_dmg;

    assign raw_cmd = {bus.apply_pd, bus.calc_ah, bus.ld_am,
                      bus.apply_ad, bus.calc_ph, bus.ld_pm};
    assign cmd     = cmd_priority(raw_cmd);

    // A held command is executed once: it must differ from the last accepted one.
    assign step_start   = (state == ST_IDLE) && !bus.start_battle &&
                          (cmd != CMD_NONE) && (cmd != last_cmd);
    assign cmd_is_apply = (cmd == CMD_APPLY_AD) || (cmd == CMD_APPLY_PD);

    assign tgt_hp    = drain_ai ? ai_hp : player_hp;
    assign drain_dec = (state == ST_DRAIN) && (dcnt != 8'd0) && (tgt_hp != 8'd0);

    // -------------------------------------------------------------------------
    // Hit roll (evaluated on the cycle a CALC step starts)
    // -------------------------------------------------------------------------
    always_comb begin
        roll_move  = (cmd == CMD_CALC_AH) ? amove : pmove;
        roll_power = move_power(roll_move);
        roll_hit_w = roll_hit(rnd, roll_move);
`ifdef PBS_CRIT_HIT_EN
        roll_crit  = roll_hit_w && (rnd[7:5] == 3'b000);
        // 2*power peaks at 100, so the shift cannot overflow 8 bits.
        roll_dmg   = roll_hit_w ? (roll_crit ? (roll_power << 1) : roll_power) : 8'd0;
`else
        roll_crit  = 1'b0;
        roll_dmg   = roll_hit_w ? roll_power : 8'd0;
`endif
    end

    // -------------------------------------------------------------------------
    // Step FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (step_start) begin
                    state_next = cmd_is_apply ? ST_DRAIN : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_DONE;
            end
            ST_DRAIN: begin
                // HP saturates at zero: a kill ends the drain early.
                if ((dcnt == 8'd0) || (tgt_hp == 8'd0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // A new battle abandons whatever step is in flight.
        if (bus.start_battle) begin
            state_next = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Command edge tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_cmd <= CMD_NONE;
        end else if (cmd == CMD_NONE) begin
            last_cmd <= CMD_NONE;
        end else if (step_start) begin
            last_cmd <= cmd;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            player_hp  <= HP_INIT;
            ai_hp      <= HP_INIT;
            player_hit <= 1'b0;
            ai_hit     <= 1'b0;
            pmove      <= 2'd0;
            amove      <= 2'd0;
            dmg        <= 8'd0;
            dcnt       <= 8'd0;
            drain_ai   <= 1'b0;
        end else if (bus.start_battle) begin
            player_hp  <= HP_INIT;
            ai_hp      <= HP_INIT;
            player_hit <= 1'b0;
            ai_hit     <= 1'b0;
            dmg        <= 8'd0;
            dcnt       <= 8'd0;
        end else begin
            if (step_start) begin
                case (cmd)
                    CMD_LD_PM: begin
                        pmove <= bus.move_in;
                    end
                    CMD_LD_AM: begin
                        amove <= lfsr[9:8];
                    end
                    CMD_CALC_PH: begin
                        player_hit <= roll_hit_w;
                        dmg        <= roll_dmg;
                    end
                    CMD_CALC_AH: begin
                        ai_hit <= roll_hit_w;
                        dmg    <= roll_dmg;
                    end
                    CMD_APPLY_AD: begin
                        dcnt     <= dmg;
                        drain_ai <= 1'b1;
                    end
                    CMD_APPLY_PD: begin
                        dcnt     <= dmg;
                        drain_ai <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
            if (drain_dec) begin
                dcnt <= dcnt - 8'd1;
                if (drain_ai) begin
                    ai_hp <= ai_hp - 8'd1;
                end else begin
                    player_hp <= player_hp - 8'd1;
                end
            end
        end
    end

`ifdef PBS_CRIT_HIT_EN
    logic crit_q;

    // crit reflects the most recent CALC step, hit or miss.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crit_q <= 1'b0;
        end else if (bus.start_battle) begin
            crit_q <= 1'b0;
        end else if (step_start &&
                     ((cmd == CMD_CALC_PH) || (cmd == CMD_CALC_AH))) begin
            crit_q <= roll_crit;
        end
    end

    assign bus.crit = crit_q;
`else
    assign bus.crit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.step_done      = (state == ST_DONE);
    assign bus.player_hit     = player_hit;
    assign bus.ai_hit         = ai_hit;
    assign bus.player_hp      = player_hp;
    assign bus.ai_hp          = ai_hp;
    assign bus.player_fainted = (player_hp == 8'd0);
    assign bus.ai_fainted     = (ai_hp == 8'd0);
    assign bus.dbg_state      = state;
    assign bus.dbg_lfsr       = lfsr;

endmodule
